// File: rtl/opl3_pkg.sv
// ---------------------------------------------------------------------------
// opl3_pkg
// Shared constants, control-word type and prescaler helper for the OPL3
// timer block (opl3_timers_n and its per-timer channel opl3_timer_chan).
//
// Optional feature macro: OPL3_TIMERS_ONE_SHOT_EN adds a per-timer oneshot
// bit to the control word.
// ---------------------------------------------------------------------------
package opl3_pkg;

    localparam int NUM_TIMERS    = 2;
    localparam int TIMER_WIDTH   = 8;
    localparam int PRESCALE_LOG2 = 2;

    // One host control-register write, as seen on the register bus.
    typedef struct packed {
        logic [NUM_TIMERS-1:0] start;
        logic [NUM_TIMERS-1:0] mask;
        logic                  irq_reset;
`ifdef OPL3_TIMERS_ONE_SHOT_EN
        logic [NUM_TIMERS-1:0] oneshot;
`endif
    } timer_ctrl_t;

    // Terminal prescaler value of timer i: the count advances once every
    // 2^(log2_step*i) base ticks.
    function automatic int prescale_max(input int i, input int log2_step = PRESCALE_LOG2);
        return (1 << (log2_step * i)) - 1;
    endfunction

endpackage

// File: rtl/opl3_timers_n_if.sv
// ---------------------------------------------------------------------------
// opl3_timers_n_if
// Host register-write bus of the OPL3 timer block.
//   preset_wr      one-hot preset load strobe, one bit per timer
//   preset_data    preset value
//   ctrl_wr        control register write strobe
//   ctrl_start     start bits        (sampled on ctrl_wr)
//   ctrl_mask      mask bits         (sampled on ctrl_wr)
//   ctrl_irq_reset flag clear request (sampled on ctrl_wr)
//   ctrl_oneshot   one-shot bits, only with OPL3_TIMERS_ONE_SHOT_EN
// master = host side (drives), slave = timer block (receives).
// ---------------------------------------------------------------------------
interface opl3_timers_n_if
    import opl3_pkg::*;
#(
    parameter int NUM_TIMERS  = opl3_pkg::NUM_TIMERS,
    parameter int TIMER_WIDTH = opl3_pkg::TIMER_WIDTH
);
    logic [NUM_TIMERS-1:0]  preset_wr;
    logic [TIMER_WIDTH-1:0] preset_data;
    logic                   ctrl_wr;
    logic [NUM_TIMERS-1:0]  ctrl_start;
    logic [NUM_TIMERS-1:0]  ctrl_mask;
    logic                   ctrl_irq_reset;
`ifdef OPL3_TIMERS_ONE_SHOT_EN
    logic [NUM_TIMERS-1:0]  ctrl_oneshot;
`endif

`ifdef OPL3_TIMERS_ONE_SHOT_EN
    modport master (output preset_wr, preset_data, ctrl_wr, ctrl_start,
                           ctrl_mask, ctrl_irq_reset, ctrl_oneshot);
    modport slave  (input  preset_wr, preset_data, ctrl_wr, ctrl_start,
                           ctrl_mask, ctrl_irq_reset, ctrl_oneshot);
`else
    modport master (output preset_wr, preset_data, ctrl_wr, ctrl_start,
                           ctrl_mask, ctrl_irq_reset);
    modport slave  (input  preset_wr, preset_data, ctrl_wr, ctrl_start,
                           ctrl_mask, ctrl_irq_reset);
`endif

endinterface

// File: rtl/opl3_timer_chan.sv
// ---------------------------------------------------------------------------
// opl3_timer_chan
// One OPL3 timer: preset register, prescaler, up-counter and start-edge
// detect. Emits a combinational overflow pulse that the parent registers
// into its flag on the same edge the count reloads.
//   clk, reset      clock, synchronous active-high reset
//   tick_en_i       base tick pulse
//   force_ovf_i     debug: overflow now if running
//   start_i         next-state start bit from the parent control register
//   preset_wr_i     preset load strobe for this timer
//   preset_data_i   preset value
//   ovf_o           overflow this cycle
// ---------------------------------------------------------------------------
module opl3_timer_chan
    import opl3_pkg::*;
#(
    parameter int INDEX         = 0,
    parameter int TIMER_WIDTH   = opl3_pkg::TIMER_WIDTH,
    parameter int PRESCALE_LOG2 = opl3_pkg::PRESCALE_LOG2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick_en_i,
    input  logic                   force_ovf_i,
    input  logic                   start_i,
    input  logic                   preset_wr_i,
    input  logic [TIMER_WIDTH-1:0] preset_data_i,
    output logic                   ovf_o
);
    // Timer 0 has no prescaling; keep a 1-bit prescaler that stays at 0.
    localparam int PW = (PRESCALE_LOG2 * INDEX > 0) ? PRESCALE_LOG2 * INDEX : 1;
    localparam logic [PW-1:0] PMAX = PW'(prescale_max(INDEX, PRESCALE_LOG2));

    logic                   run_q;
    logic [PW-1:0]          presc_q,  presc_d;
    logic [TIMER_WIDTH-1:0] count_q,  count_d;
    logic [TIMER_WIDTH-1:0] preset_q, preset_d;
    logic                   presc_wrap;
    logic                   cnt_step;

    assign presc_wrap = (presc_q == PMAX);
    assign cnt_step   = run_q & tick_en_i & presc_wrap;
    assign ovf_o      = run_q & (force_ovf_i | (cnt_step & (&count_q)));

    always_comb begin
        count_d  = count_q;
        presc_d  = presc_q;
        preset_d = preset_wr_i ? preset_data_i : preset_q;
        if (start_i && !run_q) begin
            // Start edge beats a coincident tick: load only.
            count_d = preset_q;
            presc_d = '0;
        end else if (ovf_o) begin
            count_d = preset_q;
            presc_d = '0;
        end else if (run_q && tick_en_i) begin
            presc_d = presc_wrap ? '0 : presc_q + 1'b1;
            if (presc_wrap) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q    <= 1'b0;
            presc_q  <= '0;
            count_q  <= '0;
            preset_q <= '0;
        end else begin
            run_q    <= start_i;
            presc_q  <= presc_d;
            count_q  <= count_d;
            preset_q <= preset_d;
        end
    end

endmodule

// File: rtl/opl3_timers_n.sv
// ---------------------------------------------------------------------------
// opl3_timers_n
// NUM_TIMERS independent OPL3-style up-counting timers. Timer i advances once
// every 2^(PRESCALE_LOG2*i) base ticks; overflow reloads the preset and sets
// the timer's flag unless masked. status = {IRQ, flags}, irq_n active low.
//   clk, reset            clock, synchronous active-high reset
//   tick_en               base tick pulse
//   force_timer_overflow  debug: overflow every running timer now
//   host                  register-write bus (opl3_timers_n_if.slave)
//   status                {OR of flags, per-timer flags}
//   irq_n                 active-low interrupt
// Optional: OPL3_TIMERS_ONE_SHOT_EN adds per-timer one-shot mode, where an
// overflow clears the timer's own start bit.
// ---------------------------------------------------------------------------
module opl3_timers_n
    import opl3_pkg::*;
#(
    parameter int NUM_TIMERS    = opl3_pkg::NUM_TIMERS,
    parameter int TIMER_WIDTH   = opl3_pkg::TIMER_WIDTH,
    parameter int PRESCALE_LOG2 = opl3_pkg::PRESCALE_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick_en,
    input  logic                  force_timer_overflow,
    opl3_timers_n_if.slave        host,
    output logic [NUM_TIMERS:0]   status,
    output logic                  irq_n
);
    logic [NUM_TIMERS-1:0] start_q, start_d;
    logic [NUM_TIMERS-1:0] mask_q,  mask_d;
    logic [NUM_TIMERS-1:0] flag_q,  flag_d;
    logic [NUM_TIMERS-1:0] ovf;
`ifdef OPL3_TIMERS_ONE_SHOT_EN
    logic [NUM_TIMERS-1:0] oneshot_q, oneshot_d;
`endif

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
        opl3_timer_chan #(
            .INDEX        (g),
            .TIMER_WIDTH  (TIMER_WIDTH),
            .PRESCALE_LOG2(PRESCALE_LOG2)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .tick_en_i    (tick_en),
            .force_ovf_i  (force_timer_overflow),
            .start_i      (start_d[g]),
            .preset_wr_i  (host.preset_wr[g]),
            .preset_data_i(host.preset_data),
            .ovf_o        (ovf[g])
        );
    end

    always_comb begin
        start_d = start_q;
        mask_d  = mask_q;
`ifdef OPL3_TIMERS_ONE_SHOT_EN
        oneshot_d = oneshot_q;
`endif
        // An irq_reset write carries no start/mask update.
        if (host.ctrl_wr && !host.ctrl_irq_reset) begin
            start_d = host.ctrl_start;
            mask_d  = host.ctrl_mask;
`ifdef OPL3_TIMERS_ONE_SHOT_EN
            oneshot_d = host.ctrl_oneshot;
`endif
        end
`ifdef OPL3_TIMERS_ONE_SHOT_EN
        // A one-shot timer stops itself on overflow.
        start_d = start_d & ~(ovf & oneshot_q);
`endif
        // Clear first, then set: a coincident overflow keeps its flag.
        flag_d = (host.ctrl_wr && host.ctrl_irq_reset) ? '0 : flag_q;
        flag_d = flag_d | (ovf & ~mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= '0;
            mask_q  <= '0;
            flag_q  <= '0;
`ifdef OPL3_TIMERS_ONE_SHOT_EN
            oneshot_q <= '0;
`endif
        end else begin
            start_q <= start_d;
            mask_q  <= mask_d;
            flag_q  <= flag_d;
`ifdef OPL3_TIMERS_ONE_SHOT_EN
            oneshot_q <= oneshot_d;
`endif
        end
    end

    assign status = {|flag_q, flag_q};
    assign irq_n  = ~(|flag_q);

endmodule

// File: doc/opl3_timers_n.md
Name: opl3_timers_n

Overview:
- Parametrised successor to the two-timer OPL3 block: NUM_TIMERS independent up-counting timers, each with preset, start and mask control, overflow flags and an open-drain-style active-low IRQ.
- Sits beside the channel array under the opl3 top level. Fed by host_if register writes and a base tick pulse from clk_div; drives the status byte and irq_n.
- Timer i prescales the base tick by 2^(PRESCALE_LOG2*i). With defaults this reproduces OPL3 timing: 80 us and 320 us.

Parameters:
- NUM_TIMERS, 2, number of timers (1..6).
- TIMER_WIDTH, 8, counter and preset width.
- PRESCALE_LOG2, 2, log2 of the prescale ratio step between successive timers.

Ports:
- clk  in  1  OPL3 clock.
- reset  in  1  synchronous, active-high reset.
- tick_en  in  1  base tick, one-cycle pulse (80 us period).
- preset_wr  in  NUM_TIMERS  one-hot strobe; loads preset_data into that timer's preset.
- preset_data  in  TIMER_WIDTH  preset value.
- ctrl_wr  in  1  control register write strobe.
- ctrl_start  in  NUM_TIMERS  start bits, sampled on ctrl_wr.
- ctrl_mask  in  NUM_TIMERS  mask bits, sampled on ctrl_wr.
- ctrl_irq_reset  in  1  flag clear request, sampled on ctrl_wr.
- force_timer_overflow  in  1  debug pulse that overflows all running timers.
- status  out  NUM_TIMERS+1  bit NUM_TIMERS = IRQ; bits [NUM_TIMERS-1:0] = per-timer flags.
- irq_n  out  1  active-low interrupt.

Behaviour:
- Reset: all of the following clear to 0: counts, presets, prescalers, start, mask, flags. status = 0; irq_n = 1.
- ctrl_wr with ctrl_irq_reset=1: clears all flags next edge. start and mask bits of that write are ignored (registers hold).
- ctrl_wr with ctrl_irq_reset=0: start and mask registers load.
- Start 0->1 on timer i: count loads preset and the prescaler clears on the same edge. Counting begins on the next tick_en.
- Start 1->0: count and prescaler freeze. A later restart reloads the preset.
- Running timer, each tick_en:
  - The prescaler increments.
  - When the prescaler equals 2^(PRESCALE_LOG2*i)-1, it wraps to 0 and the count increments.
  - Timer 0 has ratio 1, so it counts on every tick.
- Overflow occurs when a count increment happens with count = all-ones. The count reloads the preset on the same edge, and flag i sets if mask i = 0.
- Masked timers still count and reload, but never set their flag. Setting a mask does not clear an existing flag.
- force_timer_overflow: every running timer takes the overflow path that cycle, regardless of tick_en. The prescaler clears.
- Preset write while running: takes effect at the next reload or start. The current count is undisturbed.
- Simultaneous overflow and irq_reset: set wins. The flag ends at 1, and all other flags clear.
- Simultaneous start 0->1 and tick_en: the load wins and no increment happens that cycle.
- Preset = all-ones: overflows on every prescaled tick.
- status[NUM_TIMERS] = OR of flags; status is driven directly from registers.
- irq_n = ~status[NUM_TIMERS], driven combinationally from flag registers. Latency from overflow edge to irq_n low is 0 cycles after the registering edge.
- All sequential logic is clocked by clk only; no other clocks are used.

Optional Feature:
- Macro: OPL3_TIMERS_ONE_SHOT_EN.
- Defined: adds input ctrl_oneshot [NUM_TIMERS], sampled on ctrl_wr alongside start. A one-shot timer clears its own start bit on overflow: the count freezes at preset, the flag sets per mask, and the timer restarts only when software writes start again.
- Undefined: the port is absent and all timers auto-reload.

Decomposition:
- opl3_pkg holds:
  - constants NUM_TIMERS, TIMER_WIDTH, PRESCALE_LOG2;
  - typedef timer_ctrl_t, a packed struct of start, mask, irq_reset (plus oneshot under the macro);
  - function prescale_max(i) returning 2^(PRESCALE_LOG2*i)-1.
- Sub-module opl3_timer_chan is instantiated NUM_TIMERS times via generate. It holds the prescaler, count, preset and start-edge detect, and outputs an overflow pulse.
- Parent opl3_timers_n owns the control registers, flags, the priority between set and clear, and irq_n.

Test Plan:
- Reset mid-count (preset 0x10, 5 ticks elapsed) -> next cycle: count 0, start 0, status 0x0, irq_n 1.
- T0 preset 0xFE, start=01, tick every 4 clk -> flag0 sets after the 2nd tick. status = 0b101, irq_n = 0, count reloads to 0xFE.
- T1 preset 0xFF, start=10 -> overflow on the 4th tick, not earlier. With mask=10, same timing but status stays 0x0 and irq_n stays 1.
- Both flags set, ctrl_wr irq_reset=1 with start=00 -> status 0x0, irq_n 1, both timers keep running.
- ctrl_wr irq_reset=1 on the same cycle as a T0 overflow -> status = 0b101 afterwards; the T1 flag is cleared.
- OPL3_TIMERS_ONE_SHOT_EN, T0 oneshot preset 0xFE -> exactly one overflow, start bit reads 0, no further flags over 10 ticks. Rewriting start gives one more overflow.
